// File: rtl/dm_store_buffer_pkg.sv
// rtl/dm_store_buffer_pkg.sv - shared DM op encodings and store-entry type
//
// Purpose: the write-op and read-op encodings and the store-entry record used by
//          the CPU decoder, the data memory and the store buffer.
// Ports:   none (package).
package dm_store_buffer_pkg;

  localparam logic [1:0] WOP_WORD = 2'd0;
  localparam logic [1:0] WOP_HALF = 2'd1;
  localparam logic [1:0] WOP_BYTE = 2'd2;

  localparam logic [2:0] ROP_WORD = 3'd0;
  localparam logic [2:0] ROP_HALF = 3'd1;
  localparam logic [2:0] ROP_BYTE = 3'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
  } sb_entry_t;

  // Op 3 has no meaning of its own and behaves as a byte store.
  function automatic logic [1:0] norm_wop(input logic [1:0] op);
    return (op == 2'd3) ? WOP_BYTE : op;
  endfunction

endpackage

// File: rtl/dm_sb_match.sv
// rtl/dm_sb_match.sv - combinational load/store word-address matcher
//
// Purpose: compares a load word address against every valid store entry and
//          reports whether any matches and which matching entry is youngest.
// Ports:   waddr   - word address (bits 31:2) of every entry slot
//          head    - slot of the oldest valid entry
//          count   - number of valid entries, counted from head
//          ld_addr - load byte address
//          hit     - at least one valid entry matches
//          hit_idx - slot of the youngest matching entry
module dm_sb_match #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic [DEPTH-1:0][29:0] waddr,
  input  logic [PW-1:0]          head,
  input  logic [CW-1:0]          count,
  input  logic [31:0]            ld_addr,
  output logic                   hit,
  output logic [PW-1:0]          hit_idx
);

  // Walk from oldest to youngest; a later match overrides an earlier one, so
  // the last hit standing is the youngest. Slot index wraps naturally because
  // DEPTH is a power of two.
  always_comb begin
    logic [PW-1:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (waddr[idx] == ld_addr[31:2])) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

endmodule

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - posted-write store buffer in front of the DM write port
//
// Purpose: accepts one store per cycle into a circular FIFO and retires them in
//          order to DM whenever mem_ready is high; flags loads that hit a
//          pending store. Optional macro DM_STORE_FWD_EN forwards the youngest
//          matching word store to a word load instead of stalling.
// Ports:   st_*        - store request in (st_ready = not full)
//          mem_ready   - DM accepts a write this cycle
//          MWE/PC/addr/data/DMWop - DM write port, head entry
//          ld_*        - load probe in; ld_stall, ld_fwd_valid, ld_fwd_data out
//          empty/count - occupancy
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_pc,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_op,
  input  logic          mem_ready,
  output logic          MWE,
  output logic [31:0]   PC,
  output logic [31:0]   addr,
  output logic [31:0]   data,
  output logic [1:0]    DMWop,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [2:0]    ld_op,
  output logic          ld_stall,
  output logic          ld_fwd_valid,
  output logic [31:0]   ld_fwd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  push;
  logic                  pop;
  sb_entry_t             head_e;
  logic [DEPTH-1:0][29:0] waddr;
  logic                  hit;
  logic [PW-1:0]         hit_idx;

  // A full buffer refuses a store even while it retires one: st_ready is
  // registered-state only, so it never depends on mem_ready.
  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push     = st_valid && st_ready;
  assign pop      = !empty && mem_ready;
  assign head_e   = entries_q[head_q];

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push) begin
      entries_d[tail_q] = '{pc: st_pc, addr: st_addr, data: st_data, op: norm_wop(st_op)};
      tail_d            = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Write port: head entry is presented whenever the buffer is non-empty; the
  // enable is held off during reset because the entry is being discarded.
  always_comb begin
    MWE   = pop && !reset;
    PC    = '0;
    addr  = '0;
    data  = '0;
    DMWop = WOP_WORD;
    if (!empty) begin
      PC    = head_e.pc;
      addr  = head_e.addr;
      data  = head_e.data;
      DMWop = head_e.op;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      waddr[i] = entries_q[i].addr[31:2];
    end
  end

  dm_sb_match #(.DEPTH(DEPTH)) u_match (
    .waddr   (waddr),
    .head    (head_q),
    .count   (count_q),
    .ld_addr (ld_addr),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

`ifdef DM_STORE_FWD_EN
  // Only a full-word store can satisfy a full-word load; anything narrower
  // would need merging with DM contents, so it stalls instead.
  logic fwd_ok;
  assign fwd_ok       = hit && (entries_q[hit_idx].op == WOP_WORD) && (ld_op == ROP_WORD);
  assign ld_stall     = ld_valid && hit && !fwd_ok;
  assign ld_fwd_valid = ld_valid && fwd_ok;
  assign ld_fwd_data  = (ld_valid && fwd_ok) ? entries_q[hit_idx].data : '0;
`else
  assign ld_stall     = ld_valid && hit;
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;

  logic unused_nofwd;
  assign unused_nofwd = ^{ld_op, hit_idx};
`endif

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Posted-write buffer between the CPU datapath and the data memory (DM) write port. Stores are accepted in one cycle and retired to DM in program order, one per cycle, whenever DM signals ready. Loads to a word with a store still pending are flagged so the pipeline can stall, or are served by forwarding when that is enabled. The buffer drives DM's write port exactly as the datapath used to, with the store's PC passed along so DM's write trace stays correct.

## Interface
- DEPTH, 4, number of store entries; power of two, ≥ 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request this cycle
- st_ready  out  1  buffer can accept (not full)
- st_pc  in  32  PC of the store instruction
- st_addr  in  32  byte address
- st_data  in  32  store data, right-aligned
- st_op  in  2  0 = word, 1 = half, 2 = byte; 3 is treated as byte
- mem_ready  in  1  DM accepts a write this cycle
- MWE  out  1  DM write enable
- PC  out  32  PC of the store being retired
- addr  out  32  address to DM
- data  out  32  data to DM
- DMWop  out  2  write op to DM
- ld_valid  in  1  load in flight this cycle
- ld_addr  in  32  load byte address
- ld_op  in  3  0 = word, 1 = half, 2 = byte
- ld_stall  out  1  load conflicts with a pending store
- ld_fwd_valid  out  1  forwarded data valid (see Configuration)
- ld_fwd_data  out  32  forwarded word
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH)+1  pending entries

## Operation
- Circular FIFO of {pc, addr, data, op}. Head and tail pointers wrap modulo DEPTH. A separate count register distinguishes full from empty.
- Enqueue when st_valid && st_ready. Stores are kept unmodified; DM does the byte-lane alignment.
- st_ready = (count != DEPTH). A full buffer does not accept a store, even in a cycle when it retires one.
- Retire when count > 0 && mem_ready. In that cycle MWE = 1 and PC/addr/data/DMWop carry the head entry. The head pops at the same edge that DM writes.
- When count == 0 or mem_ready == 0: MWE = 0. When count == 0, PC/addr/data/DMWop are driven to 0.
- Enqueue and retire in the same cycle leave count unchanged.
- Conflict check: a store entry matches when the load and store have the same word address (bits 31:2), regardless of op. The check compares against all valid entries, including the head being retired this cycle. It does not check a store arriving in the same cycle.
- ld_stall = ld_valid && any match (modified by the forwarding macro).
- Entries are ordered by age. The youngest matching entry is the one used for forwarding.

## Timing
- Reset: count = 0, pointers = 0, st_ready = 1, empty = 1, MWE = 0, PC/addr/data/DMWop = 0, ld_stall = 0, ld_fwd_valid = 0, ld_fwd_data = 0.
- Reset in mid-operation discards all pending stores. Nothing is written to DM in the reset cycle.
- Latency: a store accepted at edge N is visible on MWE from cycle N+1 (no bypass to an empty buffer). It is written to DM at the first edge where it is the head and mem_ready = 1.
- Throughput: 1 store in and 1 store out per cycle.
- ld_stall, ld_fwd_* are combinational from the load inputs and the registered entries. MWE and the write-port outputs are combinational only from registered state and mem_ready.
- count, empty and st_ready update at the clock edge.

## Configuration
- DM_STORE_FWD_EN undefined: any match asserts ld_stall. ld_fwd_valid and ld_fwd_data are tied to 0.
- DM_STORE_FWD_EN defined: if the youngest matching entry is a word store and ld_op == 0, then ld_stall = 0, ld_fwd_valid = 1 and ld_fwd_data = that entry's data. Every other match stalls.

## Structure
- Shared package holds the write-op encodings (WOP_WORD, WOP_HALF, WOP_BYTE), the read-op encodings, and the store-entry struct typedef. The CPU decoder and DM use the same package.
- One sub-module: dm_sb_match, a combinational matcher over all entries. It outputs hit and youngest-hit index. The FIFO stays in the top module.

## Test plan
- Reset, then store word 0x1234_5678 to 0x10 with mem_ready = 1. Next cycle: MWE = 1, addr = 0x10, data = 0x1234_5678, DMWop = 0. The cycle after: empty = 1.
- mem_ready = 0, issue 4 stores. Then st_ready = 0 and count = 4. A 5th store is ignored. Raise mem_ready: 4 writes appear on consecutive cycles, in order.
- Full buffer with mem_ready = 1 and st_valid = 1 in the same cycle: the store is rejected and count drops to 3. Next cycle the store is accepted.
- Pending byte store to 0x21, then load word from 0x20: ld_stall = 1 in both builds. Once that store is retired: ld_stall = 0.
- With the macro defined: pending word stores 0xAAAA_AAAA then 0xBBBB_BBBB to 0x40, then load word from 0x40. Expect ld_fwd_valid = 1, ld_fwd_data = 0xBBBB_BBBB, ld_stall = 0.
- Assert reset with 3 entries pending: count = 0 next cycle, no MWE pulse, and a load to a previously pending address has ld_stall = 0.
